// File: rtl/sdp_cmux_src_arb_if.sv
// Handshake bundle between the two packet sources, the arbiter and the SDP datapath.
interface sdp_cmux_src_arb_if #(parameter int DW = 512);
  logic          src0_valid;
  logic          src0_ready;
  logic [DW-1:0] src0_pd;
  logic          src0_last;
  logic          src1_valid;
  logic          src1_ready;
  logic [DW-1:0] src1_pd;
  logic          src1_last;
  logic          dp_valid;
  logic          dp_ready;
  logic [DW-1:0] dp_pd;
  logic          dp_last;
  logic          dp_src;

  modport master (
    output src0_valid, src0_pd, src0_last,
    output src1_valid, src1_pd, src1_last,
    output dp_ready,
    input  src0_ready, src1_ready,
    input  dp_valid, dp_pd, dp_last, dp_src
  );

  modport slave (
    input  src0_valid, src0_pd, src0_last,
    input  src1_valid, src1_pd, src1_last,
    input  dp_ready,
    output src0_ready, src1_ready,
    output dp_valid, dp_pd, dp_last, dp_src
  );
endinterface

// File: rtl/sdp_cmux_src_arb.sv
// Packet-locked two-source arbiter (CACC flying stream vs DMA read stream) feeding
// a one-deep registered output stage toward the SDP datapath.
module sdp_cmux_src_arb #(
  parameter int DW   = 512,
  parameter int CNTW = 16
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic [1:0]          cfg_mode,
  sdp_cmux_src_arb_if.slave   bus,
  output logic [CNTW-1:0]     pkt_cnt,
  output logic                idle
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          rr_ptr, rr_nxt;
  logic          gnt_vld, gnt_id;
  logic          acc, take, sel_last;
  logic [DW-1:0] sel_pd;
  logic          vld_p0, last_p0, src_p0;
  logic [DW-1:0] pd_p0;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  // Grant selection: policy applies only in IDLE, a lock pins the grant until last
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    case (state)
      LOCK0: gnt_vld = 1'b1;
      LOCK1: begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
      default: begin
        case (cfg_mode)
          2'd0: begin
            if (bus.src0_valid && bus.src1_valid) begin
              gnt_vld = 1'b1;
              gnt_id  = rr_ptr;
            end else if (bus.src0_valid) begin
              gnt_vld = 1'b1;
            end else if (bus.src1_valid) begin
              gnt_vld = 1'b1;
              gnt_id  = 1'b1;
            end
          end
          2'd1: begin
            if (bus.src0_valid) begin
              gnt_vld = 1'b1;
            end else if (bus.src1_valid) begin
              gnt_vld = 1'b1;
              gnt_id  = 1'b1;
            end
          end
          2'd2: gnt_vld = bus.src0_valid;
          default: begin
            gnt_vld = bus.src1_valid;
            gnt_id  = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign acc            = !vld_p0 || bus.dp_ready;
  assign bus.src0_ready = !nvdla_core_rst && acc && gnt_vld && !gnt_id;
  assign bus.src1_ready = !nvdla_core_rst && acc && gnt_vld && gnt_id;
  assign take           = gnt_id ? (bus.src1_ready && bus.src1_valid)
                                 : (bus.src0_ready && bus.src0_valid);
  assign sel_pd         = gnt_id ? bus.src1_pd : bus.src0_pd;
  assign sel_last       = gnt_id ? bus.src1_last : bus.src0_last;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    if (take) begin
      if (sel_last) begin
        state_nxt = IDLE;
        rr_nxt    = !gnt_id;
      end else begin
        state_nxt = gnt_id ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Stage p0: registered output beat, refilled whenever the downstream slot frees up
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      src_p0  <= 1'b0;
    end else if (acc) begin
      vld_p0 <= take;
      if (take) begin
        last_p0 <= sel_last;
        src_p0  <= gnt_id;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (acc && take) begin
      pd_p0 <= sel_pd;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      pkt_cnt <= '0;
    end else if (vld_p0 && bus.dp_ready && last_p0) begin
      pkt_cnt <= sat_inc(pkt_cnt);
    end
  end

  assign bus.dp_valid = vld_p0;
  assign bus.dp_pd    = pd_p0;
  assign bus.dp_last  = last_p0;
  assign bus.dp_src   = src_p0;
  assign idle         = nvdla_core_rst || (state == IDLE && !vld_p0);

endmodule
